frame_feeder: RTL

FRAME_FEEDER -- requirements
Module: frame_feeder

---
 rtl/frame_feeder.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/frame_feeder.sv
// frame_feeder: decimating stereo frame buffer. Captures one left and one
// right camera frame (decimated by SCALE on both axes) into two
// WIDTH*HEIGHT byte arrays, then lets a consumer pop them pixel by pixel.
// Ports:
//   clk, reset (sync, active-low)
//   in_data/in_valid/in_sof/in_eol/in_cam : source camera stream
//   rd_en/image_sel                       : consumer pop request / frame select
//   image_data                            : popped pixel, latency 1
//   buffer_ready                          : both frames held and readable
//   tpat_en                               : internal test-pattern fill, only
//                                           with FRAME_FEEDER_TESTPAT_EN
module frame_feeder #(
    parameter int WIDTH  = 46,
    parameter int HEIGHT = 30,
    parameter int SCALE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       in_eol,
    input  logic       in_cam,
    input  logic       rd_en,
    input  logic       image_sel,
`ifdef FRAME_FEEDER_TESTPAT_EN
    input  logic       tpat_en,
`endif
    output logic [7:0] image_data,
    output logic       buffer_ready
);

    localparam int          NPIX = WIDTH * HEIGHT;
    localparam int          AW   = $clog2(NPIX);
    localparam logic [11:0] LAST = 12'(NPIX - 1);
    localparam logic [11:0] NEND = 12'(NPIX);
    localparam logic [9:0]  SC   = 10'(SCALE);

    typedef enum logic [1:0] {
        S_FILL,
        S_READY,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_mem_l [NPIX];
    logic [7:0]  r_mem_r [NPIX];

    logic        r_act;
    logic        r_cam;
    logic [1:0]  r_done;
    logic [9:0]  r_scol;
    logic [9:0]  r_srow;
    logic [11:0] r_waddr;
    logic [11:0] r_raddr_l;
    logic [11:0] r_raddr_r;
    logic [7:0]  r_data;

    logic        w_cap_en;
    logic        w_sof_ok;
    logic        w_cam;
    logic        w_act;
    logic [9:0]  w_col;
    logic [9:0]  w_row;
    logic [11:0] w_addr;
    logic        w_store;
    logic        w_cap_done;
    logic [11:0] w_raddr;
    logic        w_pop;
    logic        w_last_pop;
    logic        w_enter_fill;

    logic        w_we_l;
    logic        w_we_r;
    logic [11:0] w_wa;
    logic [7:0]  w_wd_l;
    logic [7:0]  w_wd_r;

`ifdef FRAME_FEEDER_TESTPAT_EN
    logic [11:0] r_tp_addr;
    logic [11:0] r_tp_col;
    logic [11:0] r_tp_row;
    logic        w_tp_run;

    assign w_cap_en = (r_state == S_FILL) && !tpat_en;
    assign w_tp_run = (r_state == S_FILL) && tpat_en && !(&r_done);
`else
    assign w_cap_en = (r_state == S_FILL);
`endif

    // An in_sof for a camera whose frame is already complete is dropped.
    assign w_sof_ok = w_cap_en && in_valid && in_sof && !r_done[in_cam];

    // Counters as seen by the current pixel: an accepted sof makes this
    // pixel source (0,0) at destination address 0.
    assign w_cam  = w_sof_ok ? in_cam : r_cam;
    assign w_act  = w_sof_ok || r_act;
    assign w_col  = w_sof_ok ? 10'd0 : r_scol;
    assign w_row  = w_sof_ok ? 10'd0 : r_srow;
    assign w_addr = w_sof_ok ? 12'd0 : r_waddr;

    assign w_store = w_cap_en && in_valid && w_act && !r_done[w_cam]
                  && ((w_col % SC) == 10'd0)
                  && ((w_row % SC) == 10'd0)
                  && (32'(w_col) < 32'(WIDTH * SCALE))
                  && (32'(w_row) < 32'(HEIGHT * SCALE));

    assign w_cap_done = w_store && (w_addr == LAST);

    assign w_raddr    = image_sel ? r_raddr_r : r_raddr_l;
    assign w_pop      = rd_en && (r_state != S_FILL) && (w_raddr != NEND);
    assign w_last_pop = w_pop && image_sel && (r_raddr_r == LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FILL: begin
                if (&r_done) w_next = S_READY;
            end
            S_READY: begin
                if (w_last_pop)  w_next = S_FILL;
                else if (rd_en)  w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last_pop) w_next = S_FILL;
            end
            default: w_next = S_FILL;
        endcase
    end

    assign w_enter_fill = (w_next == S_FILL) && (r_state != S_FILL);

    always_comb begin
        w_we_l = w_store && !w_cam;
        w_we_r = w_store && w_cam;
        w_wa   = w_addr;
        w_wd_l = in_data;
        w_wd_r = in_data;
`ifdef FRAME_FEEDER_TESTPAT_EN
        // Pattern fills both frames in one pass, one address per cycle.
        if (w_tp_run) begin
            w_we_l = 1'b1;
            w_we_r = 1'b1;
            w_wa   = r_tp_addr;
            w_wd_l = 8'(r_tp_col + r_tp_row);
            w_wd_r = 8'(r_tp_col + r_tp_row + 12'd4);
        end
`endif
    end

    // Array contents are not reset.
    always_ff @(posedge clk) begin
        if (w_we_l) r_mem_l[w_wa[AW-1:0]] <= w_wd_l;
        if (w_we_r) r_mem_r[w_wa[AW-1:0]] <= w_wd_r;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FILL;
            r_act     <= 1'b0;
            r_cam     <= 1'b0;
            r_done    <= 2'b00;
            r_scol    <= 10'd0;
            r_srow    <= 10'd0;
            r_waddr   <= 12'd0;
            r_raddr_l <= 12'd0;
            r_raddr_r <= 12'd0;
            r_data    <= 8'd0;
        end else begin
            r_state <= w_next;

            if (w_pop) begin
                if (image_sel) begin
                    r_data    <= r_mem_r[w_raddr[AW-1:0]];
                    r_raddr_r <= r_raddr_r + 12'd1;
                end else begin
                    r_data    <= r_mem_l[w_raddr[AW-1:0]];
                    r_raddr_l <= r_raddr_l + 12'd1;
                end
            end

            if (w_enter_fill) begin
                r_act     <= 1'b0;
                r_done    <= 2'b00;
                r_waddr   <= 12'd0;
                r_raddr_l <= 12'd0;
                r_raddr_r <= 12'd0;
            end else if (w_cap_en && in_valid) begin
                if (w_sof_ok) begin
                    r_act <= 1'b1;
                    r_cam <= in_cam;
                end
                if (in_eol) begin
                    r_scol <= 10'd0;
                    r_srow <= w_row + 10'd1;
                end else begin
                    r_scol <= w_col + 10'd1;
                    r_srow <= w_row;
                end
                if (w_store)    r_waddr        <= w_addr + 12'd1;
                if (w_cap_done) r_done[w_cam]  <= 1'b1;
            end
`ifdef FRAME_FEEDER_TESTPAT_EN
            else if (w_tp_run && (r_tp_addr == LAST)) begin
                r_done <= 2'b11;
            end
`endif
        end
    end

`ifdef FRAME_FEEDER_TESTPAT_EN
    always_ff @(posedge clk) begin
        if (!reset || !w_tp_run) begin
            r_tp_addr <= 12'd0;
            r_tp_col  <= 12'd0;
            r_tp_row  <= 12'd0;
        end else begin
            r_tp_addr <= r_tp_addr + 12'd1;
            if (r_tp_col == 12'(WIDTH - 1)) begin
                r_tp_col <= 12'd0;
                r_tp_row <= r_tp_row + 12'd1;
            end else begin
                r_tp_col <= r_tp_col + 12'd1;
            end
        end
    end
`endif

    assign image_data   = r_data;
    assign buffer_ready = (r_state != S_FILL);

endmodule
